// File: rtl/nibble_word_writer.sv
// Assembles a word from 4-bit hex digits by shift entry, backspace or indexed nibble write.
// Exactly one action per edge: clr > wr_en > push edge > del edge.
module nibble_word_writer #(
    parameter int unsigned N_DIGITS = 8
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    key_push,
    input  logic [3:0]              key_digit,
    input  logic                    key_del,
    input  logic                    wr_en,
    input  logic [2:0]              wr_idx,
    input  logic [3:0]              wr_data,
    input  logic                    clr,
    output logic [4*N_DIGITS-1:0]   dout,
    output logic [3:0]              cnt,
    output logic                    full,
    output logic                    upd
);
    localparam int unsigned W       = 4 * N_DIGITS;
    localparam logic [3:0]  CNT_MAX = 4'(N_DIGITS);

    logic [W-1:0] r_dout;
    logic [W-1:0] w_dout_nxt;
    logic [3:0]   r_cnt;
    logic [3:0]   w_cnt_nxt;
    logic         r_push_q;
    logic         r_del_q;
    logic         r_upd;
    logic         w_push_e;
    logic         w_del_e;
    logic         w_idx_ok;

    assign w_push_e = key_push & ~r_push_q;
    assign w_del_e  = key_del & ~r_del_q;
    assign w_idx_ok = ({1'b0, wr_idx} < CNT_MAX);

    // An out-of-range indexed write still takes the edge's single action slot.
    always_comb begin
        w_dout_nxt = r_dout;
        w_cnt_nxt  = r_cnt;
        if (clr) begin
            w_dout_nxt = '0;
            w_cnt_nxt  = '0;
        end else if (wr_en) begin
            if (w_idx_ok) begin
                for (int unsigned i = 0; i < N_DIGITS; i++) begin
                    if (i == 32'(wr_idx)) begin
                        w_dout_nxt[4*i +: 4] = wr_data;
                    end
                end
            end
        end else if (w_push_e) begin
            w_dout_nxt = (r_dout << 4) | W'(key_digit);
            if (r_cnt < CNT_MAX) begin
                w_cnt_nxt = r_cnt + 4'd1;
            end
        end else if (w_del_e) begin
            w_dout_nxt = r_dout >> 4;
            if (r_cnt != 4'd0) begin
                w_cnt_nxt = r_cnt - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_dout   <= '0;
            r_cnt    <= '0;
            r_upd    <= 1'b0;
            r_push_q <= 1'b0;
            r_del_q  <= 1'b0;
        end else begin
            r_dout   <= w_dout_nxt;
            r_cnt    <= w_cnt_nxt;
            r_upd    <= (w_dout_nxt != r_dout);
            r_push_q <= key_push;
            r_del_q  <= key_del;
        end
    end

    assign dout = r_dout;
    assign cnt  = r_cnt;
    assign full = (r_cnt == CNT_MAX);
    assign upd  = r_upd;

endmodule

// File: tb/tb_nibble_word_writer.sv
// Bench for nibble_word_writer: 8-digit and 4-digit instances share stimulus and are
// checked every cycle against an arithmetic model, plus directed literal expectations.
module tb_nibble_word_writer;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        key_push = 1'b0;
    logic [3:0]  key_digit = '0;
    logic        key_del = 1'b0;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_idx = '0;
    logic [3:0]  wr_data = '0;
    logic        clr = 1'b0;
    logic [31:0] dout8;
    logic [15:0] dout4;
    logic [3:0]  cnt8, cnt4;
    logic        full8, full4, upd8, upd4;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    nibble_word_writer #(.N_DIGITS(8)) dut8 (
        .clk(clk), .rstn(rstn), .key_push(key_push), .key_digit(key_digit),
        .key_del(key_del), .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
        .clr(clr), .dout(dout8), .cnt(cnt8), .full(full8), .upd(upd8)
    );

    nibble_word_writer #(.N_DIGITS(4)) dut4 (
        .clk(clk), .rstn(rstn), .key_push(key_push), .key_digit(key_digit),
        .key_del(key_del), .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
        .clr(clr), .dout(dout4), .cnt(cnt4), .full(full4), .upd(upd4)
    );

    // Model: the word is a number; shifting a digit in is *16+d mod 16^N, backspace is /16.
    int     NS [2] = '{8, 4};
    longint m_dout [2] = '{0, 0};
    int     m_cnt  [2] = '{0, 0};
    bit     m_upd  [2] = '{0, 0};
    bit     m_pq = 0;
    bit     m_dq = 0;

    always @(posedge clk or negedge rstn) begin
        bit     pe, de;
        longint old, p, modv;
        if (!rstn) begin
            for (int i = 0; i < 2; i++) begin
                m_dout[i] = 0;
                m_cnt[i]  = 0;
                m_upd[i]  = 0;
            end
            m_pq = 0;
            m_dq = 0;
        end else begin
            pe = key_push && !m_pq;
            de = key_del && !m_dq;
            for (int i = 0; i < 2; i++) begin
                old  = m_dout[i];
                p    = longint'(1) << (4 * int'(wr_idx));
                modv = longint'(1) << (4 * NS[i]);
                if (clr) begin
                    m_dout[i] = 0;
                    m_cnt[i]  = 0;
                end else if (wr_en) begin
                    if (int'(wr_idx) < NS[i])
                        m_dout[i] = m_dout[i] - ((m_dout[i] / p) % 16) * p + longint'(wr_data) * p;
                end else if (pe) begin
                    m_dout[i] = (m_dout[i] * 16 + longint'(key_digit)) % modv;
                    if (m_cnt[i] < NS[i]) m_cnt[i] = m_cnt[i] + 1;
                end else if (de) begin
                    m_dout[i] = m_dout[i] / 16;
                    if (m_cnt[i] > 0) m_cnt[i] = m_cnt[i] - 1;
                end
                m_upd[i] = (m_dout[i] != old);
            end
            m_pq = key_push;
            m_dq = key_del;
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    always begin
        @(posedge clk);
        #3;
        check("dout8", longint'(dout8), m_dout[0]);
        check("cnt8",  longint'(cnt8),  longint'(m_cnt[0]));
        check("full8", longint'(full8), longint'(m_cnt[0] == 8));
        check("upd8",  longint'(upd8),  longint'(m_upd[0]));
        check("dout4", longint'(dout4), m_dout[1]);
        check("cnt4",  longint'(cnt4),  longint'(m_cnt[1]));
        check("full4", longint'(full4), longint'(m_cnt[1] == 4));
        check("upd4",  longint'(upd4),  longint'(m_upd[1]));
    end

    task automatic push(input logic [3:0] d);
        @(negedge clk);
        key_push  = 1'b1;
        key_digit = d;
        @(negedge clk);
        key_push  = 1'b0;
    endtask

    task automatic del_key();
        @(negedge clk);
        key_del = 1'b1;
        @(negedge clk);
        key_del = 1'b0;
    endtask

    task automatic clear();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    initial begin
        logic [31:0] bs_dout [4];
        int          bs_cnt  [4];
        int          bs_upd  [4];
        bs_dout = '{32'h12, 32'h1, 32'h0, 32'h0};
        bs_cnt  = '{2, 1, 0, 0};
        bs_upd  = '{1, 1, 1, 0};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_dout", longint'(dout8), 0);
        check("rst_cnt",  longint'(cnt8),  0);
        check("rst_upd",  longint'(upd8),  0);
        check("rst_full", longint'(full8), 0);
        rstn = 1'b1;

        // Entry 1,2,3
        push(4'h1);
        check("entry1_upd", longint'(upd8), 1);
        push(4'h2);
        push(4'h3);
        check("entry_dout", longint'(dout8), 32'h123);
        check("entry_cnt",  longint'(cnt8),  3);
        check("entry_upd",  longint'(upd8),  1);

        // Held key acts once
        clear();
        @(negedge clk);
        key_push  = 1'b1;
        key_digit = 4'hA;
        repeat (10) @(negedge clk);
        key_push  = 1'b0;
        check("held_dout", longint'(dout8), 32'hA);
        check("held_cnt",  longint'(cnt8),  1);

        // Saturation
        clear();
        for (int d = 1; d <= 9; d++) begin
            push(4'(d));
            if (d >= 8) check("sat_full", longint'(full8), 1);
            else        check("sat_nfull", longint'(full8), 0);
        end
        check("sat_dout8", longint'(dout8), 32'h23456789);
        check("sat_cnt8",  longint'(cnt8),  8);
        check("sat_dout4", longint'(dout4), 16'h6789);
        check("sat_cnt4",  longint'(cnt4),  4);

        // Backspace
        clear();
        push(4'h1);
        push(4'h2);
        push(4'h3);
        for (int k = 0; k < 4; k++) begin
            del_key();
            check("bs_dout", longint'(dout8), longint'(bs_dout[k]));
            check("bs_cnt",  longint'(cnt8),  longint'(bs_cnt[k]));
            check("bs_upd",  longint'(upd8),  longint'(bs_upd[k]));
        end

        // Indexed write; idx 7 is out of range for the 4-digit instance
        clear();
        @(negedge clk);
        wr_en   = 1'b1;
        wr_idx  = 3'd7;
        wr_data = 4'hF;
        @(negedge clk);
        wr_en   = 1'b0;
        check("wr_dout8", longint'(dout8), 32'hF0000000);
        check("wr_cnt8",  longint'(cnt8),  0);
        check("wr_upd8",  longint'(upd8),  1);
        check("wr_dout4", longint'(dout4), 0);
        check("wr_upd4",  longint'(upd4),  0);

        // Write beats a simultaneous push edge; the push is lost
        @(negedge clk);
        wr_en     = 1'b1;
        wr_idx    = 3'd0;
        wr_data   = 4'h5;
        key_push  = 1'b1;
        key_digit = 4'h7;
        @(negedge clk);
        wr_en     = 1'b0;
        @(negedge clk);
        key_push  = 1'b0;
        check("prio_dout8", longint'(dout8), 32'hF0000005);
        check("prio_cnt8",  longint'(cnt8),  0);
        check("prio_dout4", longint'(dout4), 16'h0005);

        // Async reset mid-entry with key held through release
        clear();
        for (int d = 1; d <= 5; d++) push(4'(d));
        check("ar_cnt5", longint'(cnt8), 5);
        @(negedge clk);
        #2;
        rstn      = 1'b0;
        key_push  = 1'b1;
        key_digit = 4'h9;
        #1;
        check("ar_dout", longint'(dout8), 0);
        check("ar_cnt",  longint'(cnt8),  0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check("ar_push_dout", longint'(dout8), 32'h9);
        check("ar_push_cnt",  longint'(cnt8),  1);
        key_push = 1'b0;

        // Random phase
        repeat (3000) begin
            @(negedge clk);
            if (!rstn) rstn = 1'b1;
            else if ($urandom_range(0, 299) == 0) rstn = 1'b0;
            clr       = ($urandom_range(0, 39) == 0);
            wr_en     = ($urandom_range(0, 7) == 0);
            wr_idx    = 3'($urandom);
            wr_data   = 4'($urandom);
            key_digit = 4'($urandom);
            if ($urandom_range(0, 2) == 0) key_push = ~key_push;
            if ($urandom_range(0, 3) == 0) key_del  = ~key_del;
        end
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
